// File: rtl/noc_output_port_scheduler.sv
// Per-output-port switch allocator: round-robin over input FIFO heads, wormhole lock head->tail,
// downstream credit tracking. Optional no-progress watchdog via NOC_OUT_SCHED_WATCHDOG_EN.
module noc_output_port_scheduler #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 1,
  parameter int SEL_WIDTH         = $clog2(NUM_INPUTS),
  parameter int CRED_WIDTH        = $clog2(FLIT_BUFFER_DEPTH + 1),
  parameter int WATCHDOG_CYCLES   = 1024
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc_sync,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [NUM_INPUTS-1:0] req_is_tail,
  input  logic [NUM_INPUTS-1:0] turn_mask,
  input  logic                  credit_in,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  send_out,
  output logic [SEL_WIDTH-1:0]  sel_out,
  output logic [CRED_WIDTH-1:0] credit_count,
  output logic                  locked,
  output logic                  credit_ovf_err,
  output logic                  stall_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [CRED_WIDTH-1:0] CRED_MAX = CRED_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [SEL_WIDTH-1:0]  LAST_IDX = SEL_WIDTH'(NUM_INPUTS - 1);

  logic [0:0]            state_q, state_d;
  logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_WIDTH-1:0]  owner_q, owner_d;
  logic [CRED_WIDTH-1:0] credit_q, credit_d;
  logic                  ovf_q, ovf_d;

  logic [NUM_INPUTS-1:0] eligible;
  logic                  avail;
  logic                  win_found;
  logic [SEL_WIDTH-1:0]  win_idx;
  logic [SEL_WIDTH-1:0]  gnt_idx;
  logic                  send_int;
  int                    idx;

  assign avail = (credit_q != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_elig
      assign eligible[gi] = req[gi] & ~turn_mask[gi];
    end
  endgenerate

  // Scan starts at rr_ptr and wraps explicitly so non-power-of-2 input counts work.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = SEL_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    send_int = 1'b0;
    gnt_idx  = '0;
    if (!rst_noc_sync && avail) begin
      if (state_q == ST_IDLE) begin
        send_int = win_found;
        gnt_idx  = win_idx;
      end else begin
        send_int = req[owner_q];
        gnt_idx  = owner_q;
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_grant
      assign grant[gi] = send_int && (gnt_idx == SEL_WIDTH'(gi));
    end
  endgenerate

  assign send_out = send_int;
  assign sel_out  = send_int ? gnt_idx : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (send_int) begin
      if (state_q == ST_IDLE) begin
        rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + SEL_WIDTH'(1);
        if (!req_is_tail[win_idx]) begin
          state_d = ST_LOCKED;
          owner_d = win_idx;
        end
      end else if (req_is_tail[owner_q]) begin
        state_d = ST_IDLE;
      end
    end
  end

  // A returned credit and a sent flit in the same cycle cancel out.
  always_comb begin
    credit_d = credit_q;
    ovf_d    = ovf_q;
    case ({send_int, credit_in})
      2'b10:   credit_d = credit_q - CRED_WIDTH'(1);
      2'b01: begin
        if (credit_q == CRED_MAX) ovf_d = 1'b1;
        else                      credit_d = credit_q + CRED_WIDTH'(1);
      end
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      credit_q <= CRED_MAX;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  assign credit_count   = credit_q;
  assign locked         = (state_q == ST_LOCKED);
  assign credit_ovf_err = ovf_q;

`ifdef NOC_OUT_SCHED_WATCHDOG_EN
  localparam int WD_WIDTH = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
  logic                stall_q, stall_d;

  // Counter saturates at the limit; stall flag is sticky until reset.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    stall_d  = stall_q;
    if (send_int || state_q == ST_IDLE) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_WIDTH'(WATCHDOG_CYCLES)) begin
      wd_cnt_d = wd_cnt_q + WD_WIDTH'(1);
      if (wd_cnt_q == WD_WIDTH'(WATCHDOG_CYCLES - 1)) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wd_cnt_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_err = stall_q;
`else
  // Constant 0 for any legal limit; the limit only matters with the watchdog built in.
  assign stall_err = (WATCHDOG_CYCLES < 0);
`endif

endmodule
